// File: rtl/fib_index_pkg.sv
// Shared types, sizes and helpers for the Fibonacci index finder.
package fib_index_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BCD2BIN,
    FIB,
    BIN2BCD,
    DONE
  } state_e;

  localparam int unsigned BCD_W          = 16;
  localparam int unsigned IDX_BCD_W      = 8;
  localparam int unsigned BCD2BIN_CYCLES = 16;
  localparam int unsigned BIN2BCD_CYCLES = 5;
  localparam int unsigned MAX_INDEX      = 20;
  localparam int unsigned CNT_W          = $clog2(BCD2BIN_CYCLES);

  // True when every nibble of the input is a legal decimal digit.
  function automatic logic bcd_digits_valid(input logic [BCD_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(BCD_W / 4); i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/fibonacci_index_finder_if.sv
// Start/result handshake between the switch front end and the finder.
interface fibonacci_index_finder_if;
  import fib_index_pkg::*;

  logic                 start_i;
  logic [BCD_W-1:0]     value_bcd_i;
  logic                 ready_o;
  logic                 done_tick_o;
  logic [IDX_BCD_W-1:0] index_bcd_o;
  logic                 exact_o;
  logic                 error_o;

  modport master (
    output start_i, value_bcd_i,
    input  ready_o, done_tick_o, index_bcd_o, exact_o, error_o
  );

  modport slave (
    input  start_i, value_bcd_i,
    output ready_o, done_tick_o, index_bcd_o, exact_o, error_o
  );
endinterface

// File: rtl/fibonacci_index_finder.sv
// Finds the largest n with F(n) <= V for a 4-digit BCD V, reporting n in BCD
// and whether V is itself a Fibonacci number.
module fibonacci_index_finder
  import fib_index_pkg::*;
#(
  parameter int unsigned FIB_W = 14,
  parameter int unsigned IDX_W = 5
) (
  input logic                     clk_i,
  input logic                     reset_ni,
  fibonacci_index_finder_if.slave bus
);

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [BCD_W-1:0]               bcd_q, bcd_d;
  logic [BCD_W-1:0]               bin_q, bin_d;
  logic [FIB_W-1:0]               f0_q, f0_d;
  logic [FIB_W-1:0]               f1_q, f1_d;
  logic [IDX_W-1:0]               n_q, n_d;
  logic [IDX_BCD_W-1:0]           index_q, index_d;
  logic                           exact_q, exact_d;
  logic                           error_q, error_d;

  logic [BCD_W-1:0]               bcd_shr;
  logic [IDX_BCD_W+IDX_W-1:0]     dd;

  // Next-state and datapath: BCD->binary, Fibonacci walk, binary->BCD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    f0_d    = f0_q;
    f1_d    = f1_q;
    n_d     = n_q;
    index_d = index_q;
    exact_d = exact_q;
    error_d = error_q;
    bcd_shr = '0;
    dd      = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bcd_digits_valid(bus.value_bcd_i)) begin
            bcd_d   = bus.value_bcd_i;
            bin_d   = '0;
            error_d = 1'b0;
            cnt_d   = CNT_W'(BCD2BIN_CYCLES - 1);
            state_d = BCD2BIN;
          end else begin
            // Bad digit: one zero-index pass through BIN2BCD clears the index
            // through the normal load path.
            error_d = 1'b1;
            exact_d = 1'b0;
            bcd_d   = '0;
            n_d     = '0;
            cnt_d   = '0;
            state_d = BIN2BCD;
          end
        end
      end

      BCD2BIN: begin
        {bcd_shr, bin_d} = {bcd_q, bin_q} >> 1;
        // After a right shift a digit is either <= 4 or >= 8; the latter
        // picked up 8 from the digit above where 5 was meant.
        for (int i = 0; i < int'(BCD_W / 4); i++) begin
          if (bcd_shr[4*i +: 4] > 4'd4) bcd_shr[4*i +: 4] = bcd_shr[4*i +: 4] - 4'd3;
        end
        bcd_d = bcd_shr;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          f0_d    = '0;
          f1_d    = {{(FIB_W-1){1'b0}}, 1'b1};
          n_d     = '0;
          state_d = FIB;
        end
      end

      FIB: begin
        if (f1_q > bin_q[FIB_W-1:0]) begin
          exact_d = (f0_q == bin_q[FIB_W-1:0]);
          bcd_d   = '0;
          cnt_d   = CNT_W'(BIN2BCD_CYCLES - 1);
          state_d = BIN2BCD;
        end else begin
          f0_d = f1_q;
          f1_d = f0_q + f1_q;
          n_d  = n_q + 1'b1;
        end
      end

      BIN2BCD: begin
        dd = {bcd_q[IDX_BCD_W-1:0], n_q};
        for (int i = 0; i < int'(IDX_BCD_W / 4); i++) begin
          if (dd[IDX_W + 4*i +: 4] >= 4'd5) dd[IDX_W + 4*i +: 4] = dd[IDX_W + 4*i +: 4] + 4'd3;
        end
        dd    = dd << 1;
        bcd_d = {{(BCD_W-IDX_BCD_W){1'b0}}, dd[IDX_W +: IDX_BCD_W]};
        n_d   = dd[IDX_W-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          index_d = dd[IDX_W +: IDX_BCD_W];
          state_d = DONE;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      f0_q    <= '0;
      f1_q    <= '0;
      n_q     <= '0;
      index_q <= '0;
      exact_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      f0_q    <= f0_d;
      f1_q    <= f1_d;
      n_q     <= n_d;
      index_q <= index_d;
      exact_q <= exact_d;
      error_q <= error_d;
    end
  end

  assign bus.ready_o     = (state_q == IDLE);
  assign bus.done_tick_o = (state_q == DONE);
  assign bus.index_bcd_o = index_q;
  assign bus.exact_o     = exact_q;
  assign bus.error_o     = error_q;

endmodule

// File: tb/tb_fibonacci_index_finder.sv
// Self-checking bench for fibonacci_index_finder.
module tb_fibonacci_index_finder;

  typedef struct {
    logic [15:0] v;
    logic [7:0]  idx;
    logic        exact;
    logic        err;
    int          lat;
  } vec_t;

  logic clk_i;
  logic reset_ni;
  int   total;
  int   bad;
  vec_t sb[$];
  vec_t vecs[13];

  fibonacci_index_finder_if bus ();

  fibonacci_index_finder dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outputs are sampled on negedges; the k-th negedge after the accepting
  // edge shows what edge k samples.
  task automatic run_op(input logic [15:0] v, input logic [7:0] idx, input logic ex,
                        input logic er, input int lat, input int poke_k,
                        input logic [15:0] poke_v, input bit start_in_done);
    vec_t e;
    vec_t got;
    int   done_k;
    @(negedge clk_i);
    check("ready_before_start", 32'(bus.ready_o), 1);
    bus.start_i     = 1'b1;
    bus.value_bcd_i = v;
    e = '{v, idx, ex, er, lat};
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    bus.start_i     = 1'b0;
    bus.value_bcd_i = 16'h9999;
    done_k = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk_i);
      if (bus.done_tick_o) begin
        done_k = k;
        break;
      end
      if (k == 1) check("busy_ready_low", 32'(bus.ready_o), 0);
      if (k == poke_k) begin
        bus.start_i     = 1'b1;
        bus.value_bcd_i = poke_v;
      end else begin
        bus.start_i = 1'b0;
      end
    end
    bus.start_i = 1'b0;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      got = sb.pop_front();
      if (done_k == 0) begin
        check("done_timeout", 0, 1);
      end else begin
        check("latency", 32'(done_k), 32'(got.lat));
        check("index_bcd", 32'(bus.index_bcd_o), 32'(got.idx));
        check("exact", 32'(bus.exact_o), 32'(got.exact));
        check("error", 32'(bus.error_o), 32'(got.err));
        check("ready_in_done", 32'(bus.ready_o), 0);
      end
    end
    if (start_in_done) begin
      bus.start_i     = 1'b1;
      bus.value_bcd_i = 16'h0001;
    end
    @(negedge clk_i);
    bus.start_i = 1'b0;
    check("done_one_cycle", 32'(bus.done_tick_o), 0);
    check("ready_after_done", 32'(bus.ready_o), 1);
  endtask

  initial begin
    bit saw_done;
    total           = 0;
    bad             = 0;
    reset_ni        = 1'b0;
    bus.start_i     = 1'b0;
    bus.value_bcd_i = 16'h0000;

    vecs[0]  = '{16'h0000, 8'h00, 1'b1, 1'b0, 23};
    vecs[1]  = '{16'h0001, 8'h02, 1'b1, 1'b0, 25};
    vecs[2]  = '{16'h0100, 8'h11, 1'b0, 1'b0, 34};
    vecs[3]  = '{16'h0089, 8'h11, 1'b1, 1'b0, 34};
    vecs[4]  = '{16'h0002, 8'h03, 1'b1, 1'b0, 26};
    vecs[5]  = '{16'h0004, 8'h04, 1'b0, 1'b0, 27};
    vecs[6]  = '{16'h0987, 8'h16, 1'b1, 1'b0, 39};
    vecs[7]  = '{16'h6764, 8'h19, 1'b0, 1'b0, 42};
    vecs[8]  = '{16'h6765, 8'h20, 1'b1, 1'b0, 43};
    vecs[9]  = '{16'h9999, 8'h20, 1'b0, 1'b0, 43};
    vecs[10] = '{16'h12A4, 8'h00, 1'b0, 1'b1, 2};
    vecs[11] = '{16'h0013, 8'h07, 1'b1, 1'b0, 30};
    vecs[12] = '{16'hF000, 8'h00, 1'b0, 1'b1, 2};

    // Reset for two edges, then check idle outputs.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    check("rst_ready", 32'(bus.ready_o), 1);
    check("rst_index", 32'(bus.index_bcd_o), 0);
    check("rst_exact", 32'(bus.exact_o), 0);
    check("rst_error", 32'(bus.error_o), 0);
    check("rst_done", 32'(bus.done_tick_o), 0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      if (bus.done_tick_o) saw_done = 1'b1;
    end
    check("rst_no_done", 32'(saw_done), 0);

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].v, vecs[i].idx, vecs[i].exact, vecs[i].err, vecs[i].lat, 0, 16'h0, 1'b0);
    end

    // Start pulse mid-BCD2BIN with another value must be ignored.
    run_op(16'h0100, 8'h11, 1'b0, 1'b0, 34, 5, 16'h9999, 1'b0);
    // Start during the DONE cycle must not be accepted.
    run_op(16'h0002, 8'h03, 1'b1, 1'b0, 26, 0, 16'h0, 1'b1);

    // Reset while walking the Fibonacci sequence.
    @(negedge clk_i);
    bus.start_i     = 1'b1;
    bus.value_bcd_i = 16'h9999;
    @(posedge clk_i);
    #1;
    bus.start_i = 1'b0;
    repeat (19) @(negedge clk_i);
    check("hold_index_busy", 32'(bus.index_bcd_o), 32'h03);
    check("hold_exact_busy", 32'(bus.exact_o), 1);
    reset_ni = 1'b0;
    @(negedge clk_i);
    check("abort_ready", 32'(bus.ready_o), 1);
    check("abort_index", 32'(bus.index_bcd_o), 0);
    check("abort_exact", 32'(bus.exact_o), 0);
    check("abort_error", 32'(bus.error_o), 0);
    check("abort_done", 32'(bus.done_tick_o), 0);
    reset_ni = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk_i);
      if (bus.done_tick_o) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 0);
    check("abort_sb_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
